// File: rtl/reorder_buffer_pkg.sv
// Shared width parameters for the reorder buffer and the reservation stations that talk to it.
package reorder_buffer_pkg;

  localparam int unsigned ROB_WORD_SIZE = 32;
  localparam int unsigned ROB_REG_INDEX = 5;
  localparam int unsigned ROB_RB_INDEX  = 3;

endpackage

// File: rtl/reorder_buffer_if.sv
// Issue, writeback, operand-query and commit signals of the reorder buffer.
interface reorder_buffer_if
  import reorder_buffer_pkg::*;
#(
  parameter int unsigned WORD_SIZE = ROB_WORD_SIZE,
  parameter int unsigned REG_INDEX = ROB_REG_INDEX,
  parameter int unsigned RB_INDEX  = ROB_RB_INDEX
);

  logic                 issue_valid;
  logic [REG_INDEX-1:0] issue_reg;
  logic                 issue_ready;
  logic [RB_INDEX-1:0]  issue_index;

  logic                 wb_valid;
  logic [RB_INDEX-1:0]  wb_index;
  logic [WORD_SIZE-1:0] wb_result;

  logic [RB_INDEX-1:0]  query_index_j;
  logic [RB_INDEX-1:0]  query_index_k;
  logic                 query_ready_j;
  logic                 query_ready_k;
  logic [WORD_SIZE-1:0] query_value_j;
  logic [WORD_SIZE-1:0] query_value_k;

  logic                 commit_valid;
  logic [REG_INDEX-1:0] commit_reg;
  logic [WORD_SIZE-1:0] commit_value;
  logic [RB_INDEX:0]    count;

  modport master (
    output issue_valid, issue_reg, wb_valid, wb_index, wb_result,
           query_index_j, query_index_k,
    input  issue_ready, issue_index, query_ready_j, query_ready_k,
           query_value_j, query_value_k, commit_valid, commit_reg,
           commit_value, count
  );

  modport slave (
    input  issue_valid, issue_reg, wb_valid, wb_index, wb_result,
           query_index_j, query_index_k,
    output issue_ready, issue_index, query_ready_j, query_ready_k,
           query_value_j, query_value_k, commit_valid, commit_reg,
           commit_value, count
  );

endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate, out-of-order writeback, in-order single retire per cycle.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int unsigned WORD_SIZE = ROB_WORD_SIZE,
  parameter int unsigned REG_INDEX = ROB_REG_INDEX,
  parameter int unsigned RB_INDEX  = ROB_RB_INDEX
) (
  input logic            clk,
  input logic            reset,
  reorder_buffer_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** RB_INDEX;
  localparam logic [RB_INDEX:0] FULL_COUNT = {1'b1, {RB_INDEX{1'b0}}};

  logic [DEPTH-1:0]     busy_q, busy_d;
  logic [DEPTH-1:0]     done_q, done_d;
  logic [REG_INDEX-1:0] dest_q  [DEPTH];
  logic [REG_INDEX-1:0] dest_d  [DEPTH];
  logic [WORD_SIZE-1:0] value_q [DEPTH];
  logic [WORD_SIZE-1:0] value_d [DEPTH];

  logic [RB_INDEX-1:0]  head_q, head_d;
  logic [RB_INDEX-1:0]  tail_q, tail_d;
  logic [RB_INDEX:0]    count_q, count_d;

  logic                 commit_valid_q, commit_valid_d;
  logic [REG_INDEX-1:0] commit_reg_q, commit_reg_d;
  logic [WORD_SIZE-1:0] commit_value_q, commit_value_d;

  logic alloc;
  logic retire;

  // Ready comes from registered count only, so a retire never frees space in its own cycle.
  assign bus.issue_ready  = (count_q != FULL_COUNT);
  assign bus.issue_index  = tail_q;
  assign bus.count        = count_q;
  assign bus.commit_valid = commit_valid_q;
  assign bus.commit_reg   = commit_reg_q;
  assign bus.commit_value = commit_value_q;

  assign alloc  = bus.issue_valid && bus.issue_ready;
  assign retire = busy_q[head_q] && done_q[head_q];

  always_comb begin
    busy_d         = busy_q;
    done_d         = done_q;
    dest_d         = dest_q;
    value_d        = value_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    commit_valid_d = 1'b0;
    commit_reg_d   = commit_reg_q;
    commit_value_d = commit_value_q;

    if (bus.wb_valid && busy_q[bus.wb_index]) begin
      done_d[bus.wb_index]  = 1'b1;
      value_d[bus.wb_index] = bus.wb_result;
    end

    // The tail slot is always free when allocating, so it cannot collide with the writeback above.
    if (alloc) begin
      busy_d[tail_q] = 1'b1;
      done_d[tail_q] = 1'b0;
      dest_d[tail_q] = bus.issue_reg;
      tail_d         = tail_q + 1'b1;
    end

    if (retire) begin
      commit_valid_d = 1'b1;
      commit_reg_d   = dest_q[head_q];
      commit_value_d = value_q[head_q];
      busy_d[head_q] = 1'b0;
      done_d[head_q] = 1'b0;
      head_d         = head_q + 1'b1;
    end

    if (alloc && !retire) begin
      count_d = count_q + 1'b1;
    end else if (retire && !alloc) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q         <= '0;
      done_q         <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_reg_q   <= '0;
      commit_value_q <= '0;
    end else begin
      busy_q         <= busy_d;
      done_q         <= done_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_valid_q <= commit_valid_d;
      commit_reg_q   <= commit_reg_d;
      commit_value_q <= commit_value_d;
    end
  end

  // Payload fields are qualified by busy/done, so they need no reset.
  always_ff @(posedge clk) begin
    dest_q  <= dest_d;
    value_q <= value_d;
  end

  always_comb begin
    bus.query_ready_j = busy_q[bus.query_index_j] && done_q[bus.query_index_j];
    bus.query_value_j = value_q[bus.query_index_j];
    if (bus.wb_valid && (bus.wb_index == bus.query_index_j) && busy_q[bus.query_index_j]) begin
      bus.query_ready_j = 1'b1;
      bus.query_value_j = bus.wb_result;
    end

    bus.query_ready_k = busy_q[bus.query_index_k] && done_q[bus.query_index_k];
    bus.query_value_k = value_q[bus.query_index_k];
    if (bus.wb_valid && (bus.wb_index == bus.query_index_k) && busy_q[bus.query_index_k]) begin
      bus.query_ready_k = 1'b1;
      bus.query_value_k = bus.wb_result;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed table, corner sequences, and random traffic vs a queue model.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  localparam int unsigned WS    = ROB_WORD_SIZE;
  localparam int unsigned RI    = ROB_REG_INDEX;
  localparam int unsigned BI    = ROB_RB_INDEX;
  localparam int          DEPTH = 1 << BI;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reorder_buffer_if #(.WORD_SIZE(WS), .REG_INDEX(RI), .RB_INDEX(BI)) bus ();

  reorder_buffer #(.WORD_SIZE(WS), .REG_INDEX(RI), .RB_INDEX(BI)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int passed = 0;
  int total  = 0;

  // Reference model: occupied entries in program order, oldest first.
  typedef struct {
    logic [RI-1:0] reg_no;
    logic          done;
    logic [WS-1:0] value;
  } ent_t;

  ent_t          mq[$];
  int            m_head;
  int            m_tail;
  logic          exp_cv;
  logic [RI-1:0] exp_creg;
  logic [WS-1:0] exp_cval;

  typedef struct {
    logic          iv;
    logic [RI-1:0] ireg;
    logic          wv;
    logic [BI-1:0] wi;
    logic [WS-1:0] wr;
    logic [BI:0]   e_count;
    logic [BI-1:0] e_idx;
    logic          e_cv;
    logic [RI-1:0] e_creg;
    logic [WS-1:0] e_cval;
  } vec_t;

  vec_t vt[7];

  task automatic check(input string name, input logic [WS-1:0] act, input logic [WS-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  function automatic int pos_of(input int idx);
    return (idx - m_head + DEPTH) % DEPTH;
  endfunction

  task automatic exp_query(input int qi, output logic rdy, output logic [WS-1:0] val);
    int p;
    p   = pos_of(qi);
    rdy = 1'b0;
    val = '0;
    if (p < mq.size()) begin
      if (bus.wb_valid && int'(bus.wb_index) == qi) begin
        rdy = 1'b1;
        val = bus.wb_result;
      end else if (mq[p].done) begin
        rdy = 1'b1;
        val = mq[p].value;
      end
    end
  endtask

  task automatic model_check_comb();
    logic          r;
    logic [WS-1:0] v;
    check("count", WS'(bus.count), WS'(mq.size()));
    check("issue_ready", WS'(bus.issue_ready), WS'(mq.size() < DEPTH));
    check("issue_index", WS'(bus.issue_index), WS'(m_tail));
    check("commit_valid", WS'(bus.commit_valid), WS'(exp_cv));
    check("commit_reg", WS'(bus.commit_reg), WS'(exp_creg));
    check("commit_value", bus.commit_value, exp_cval);
    exp_query(int'(bus.query_index_j), r, v);
    check("query_ready_j", WS'(bus.query_ready_j), WS'(r));
    if (r) check("query_value_j", bus.query_value_j, v);
    exp_query(int'(bus.query_index_k), r, v);
    check("query_ready_k", WS'(bus.query_ready_k), WS'(r));
    if (r) check("query_value_k", bus.query_value_k, v);
  endtask

  task automatic model_edge();
    bit   do_retire;
    bit   do_alloc;
    ent_t h;
    int   p;
    if (reset) begin
      mq.delete();
      m_head   = 0;
      m_tail   = 0;
      exp_cv   = 1'b0;
      exp_creg = '0;
      exp_cval = '0;
      return;
    end
    do_retire = (mq.size() > 0) && mq[0].done;
    if (do_retire) h = mq[0];
    do_alloc = bus.issue_valid && (mq.size() < DEPTH);
    if (bus.wb_valid) begin
      p = pos_of(int'(bus.wb_index));
      if (p < mq.size()) begin
        mq[p].done  = 1'b1;
        mq[p].value = bus.wb_result;
      end
    end
    exp_cv = do_retire;
    if (do_retire) begin
      void'(mq.pop_front());
      m_head   = (m_head + 1) % DEPTH;
      exp_creg = h.reg_no;
      exp_cval = h.value;
    end
    if (do_alloc) begin
      mq.push_back('{reg_no: bus.issue_reg, done: 1'b0, value: '0});
      m_tail = (m_tail + 1) % DEPTH;
    end
  endtask

  task automatic drive(input logic iv, input logic [RI-1:0] ireg, input logic wv,
                       input logic [BI-1:0] wi, input logic [WS-1:0] wr,
                       input logic [BI-1:0] qj, input logic [BI-1:0] qk, input logic rst);
    bus.issue_valid   = iv;
    bus.issue_reg     = ireg;
    bus.wb_valid      = wv;
    bus.wb_index      = wi;
    bus.wb_result     = wr;
    bus.query_index_j = qj;
    bus.query_index_k = qk;
    reset             = rst;
    #1;
    model_check_comb();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0, '0, '0, '0, 1'b0);
    tick();
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b0, '0, '0, '0, '0, 1'b1);
    tick();
  endtask

  task automatic issue(input logic [RI-1:0] r);
    drive(1'b1, r, 1'b0, '0, '0, '0, '0, 1'b0);
    tick();
  endtask

  task automatic wb(input logic [BI-1:0] i, input logic [WS-1:0] v);
    drive(1'b0, '0, 1'b1, i, v, '0, '0, 1'b0);
    tick();
  endtask

  initial begin
    vt[0] = '{1'b1, 5'd3, 1'b0, 3'd0, 32'h0,  4'd1, 3'd1, 1'b0, 5'd0, 32'h0};
    vt[1] = '{1'b1, 5'd5, 1'b0, 3'd0, 32'h0,  4'd2, 3'd2, 1'b0, 5'd0, 32'h0};
    vt[2] = '{1'b0, 5'd0, 1'b1, 3'd1, 32'h22, 4'd2, 3'd2, 1'b0, 5'd0, 32'h0};
    vt[3] = '{1'b0, 5'd0, 1'b1, 3'd0, 32'h11, 4'd2, 3'd2, 1'b0, 5'd0, 32'h0};
    vt[4] = '{1'b0, 5'd0, 1'b0, 3'd0, 32'h0,  4'd1, 3'd2, 1'b1, 5'd3, 32'h11};
    vt[5] = '{1'b0, 5'd0, 1'b0, 3'd0, 32'h0,  4'd0, 3'd2, 1'b1, 5'd5, 32'h22};
    vt[6] = '{1'b0, 5'd0, 1'b0, 3'd0, 32'h0,  4'd0, 3'd2, 1'b0, 5'd5, 32'h22};

    bus.issue_valid   = 1'b0;
    bus.issue_reg     = '0;
    bus.wb_valid      = 1'b0;
    bus.wb_index      = '0;
    bus.wb_result     = '0;
    bus.query_index_j = '0;
    bus.query_index_k = '0;
    reset             = 1'b1;
    repeat (2) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
    end

    // Directed table: issue, out-of-order writeback, in-order commits.
    for (int i = 0; i < 7; i++) begin
      drive(vt[i].iv, vt[i].ireg, vt[i].wv, vt[i].wi, vt[i].wr, '0, '0, 1'b0);
      tick();
      check($sformatf("tbl%0d_count", i), WS'(bus.count), WS'(vt[i].e_count));
      check($sformatf("tbl%0d_index", i), WS'(bus.issue_index), WS'(vt[i].e_idx));
      check($sformatf("tbl%0d_cv", i), WS'(bus.commit_valid), WS'(vt[i].e_cv));
      check($sformatf("tbl%0d_creg", i), WS'(bus.commit_reg), WS'(vt[i].e_creg));
      check($sformatf("tbl%0d_cval", i), bus.commit_value, vt[i].e_cval);
    end

    // Fill, overflow attempt, retire, wrap of the allocation index.
    do_reset();
    for (int i = 0; i < DEPTH; i++) issue(RI'(i + 1));
    check("full_count", WS'(bus.count), WS'(DEPTH));
    check("full_ready", WS'(bus.issue_ready), 0);
    issue(5'd9);
    check("overflow_count", WS'(bus.count), WS'(DEPTH));
    check("overflow_index", WS'(bus.issue_index), 0);
    wb(3'd0, 32'h55);
    check("wb_no_retire_yet", WS'(bus.commit_valid), 0);
    idle();
    check("wrap_cv", WS'(bus.commit_valid), 1);
    check("wrap_creg", WS'(bus.commit_reg), 1);
    check("wrap_cval", bus.commit_value, 32'h55);
    check("wrap_ready", WS'(bus.issue_ready), 1);
    drive(1'b1, 5'd10, 1'b0, '0, '0, '0, '0, 1'b0);
    check("wrap_alloc_index", WS'(bus.issue_index), 0);
    tick();
    check("wrap_refill_count", WS'(bus.count), WS'(DEPTH));

    // Writeback forwarded to a same-cycle operand query.
    do_reset();
    for (int i = 0; i < 3; i++) issue(RI'(i + 4));
    drive(1'b0, '0, 1'b1, 3'd2, 32'hABCD, 3'd2, 3'd1, 1'b0);
    check("fwd_ready_j", WS'(bus.query_ready_j), 1);
    check("fwd_value_j", bus.query_value_j, 32'hABCD);
    check("fwd_ready_k", WS'(bus.query_ready_k), 0);
    tick();

    // Full buffer with head done: issue in the retire cycle is dropped.
    do_reset();
    for (int i = 0; i < DEPTH; i++) issue(RI'(i + 11));
    wb(3'd0, 32'h77);
    drive(1'b1, 5'd20, 1'b0, '0, '0, '0, '0, 1'b0);
    tick();
    check("full_retire_count", WS'(bus.count), WS'(DEPTH - 1));
    check("full_retire_cv", WS'(bus.commit_valid), 1);
    check("full_retire_index", WS'(bus.issue_index), 0);

    // Reset mid-operation dominates same-cycle issue and writeback.
    do_reset();
    for (int i = 0; i < 4; i++) issue(RI'(i + 1));
    wb(3'd1, 32'h100);
    wb(3'd3, 32'h300);
    drive(1'b1, 5'd7, 1'b1, 3'd0, 32'h999, '0, '0, 1'b1);
    tick();
    check("rst_count", WS'(bus.count), 0);
    check("rst_cv", WS'(bus.commit_valid), 0);
    check("rst_index", WS'(bus.issue_index), 0);
    for (int i = 0; i < 5; i++) begin
      idle();
      check($sformatf("rst_quiet%0d", i), WS'(bus.commit_valid), 0);
    end

    // Random traffic against the queue model.
    for (int c = 0; c < 3000; c++) begin
      drive(logic'($urandom_range(0, 9) < 6), RI'($urandom),
            logic'($urandom_range(0, 1)), BI'($urandom), WS'($urandom),
            BI'($urandom), BI'($urandom), logic'($urandom_range(0, 99) == 0));
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL take parameter WORD_SIZE, default 32, data word width.
REQ-002 SHALL take parameter REG_INDEX, default 5, architectural register number width.
REQ-003 SHALL take parameter RB_INDEX, default 3, entry index width; depth DEPTH = 2**RB_INDEX (8).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port issue_valid  input  1  issue stage requests an entry.
REQ-007 SHALL have port issue_reg  input  REG_INDEX  destination register of the issuing instruction.
REQ-008 SHALL have port issue_ready  output  1  entry available (count < DEPTH).
REQ-009 SHALL have port issue_index  output  RB_INDEX  index to be allocated (tail), passed to the reservation station as its RB_index.
REQ-010 SHALL have port wb_valid  input  1  reservation station result valid.
REQ-011 SHALL have port wb_index  input  RB_INDEX  entry the result belongs to.
REQ-012 SHALL have port wb_result  input  WORD_SIZE  result value.
REQ-013 SHALL have ports query_index_j, query_index_k  input  RB_INDEX  operand lookup indices.
REQ-014 SHALL have ports query_ready_j, query_ready_k  output  1  queried entry holds a result.
REQ-015 SHALL have ports query_value_j, query_value_k  output  WORD_SIZE  queried entry value.
REQ-016 SHALL have port commit_valid  output  1  one-cycle pulse, an entry retired.
REQ-017 SHALL have port commit_reg  output  REG_INDEX  register written by the retiring entry.
REQ-018 SHALL have port commit_value  output  WORD_SIZE  value written.
REQ-019 SHALL have port count  output  RB_INDEX+1  occupied entries, 0..DEPTH.

Function
REQ-020 SHALL hold per entry: busy, done, dest reg, value; circular buffer with head, tail pointers wrapping DEPTH-1 -> 0.
REQ-021 SHALL allocate when issue_valid && issue_ready: entry[tail] busy=1, done=0, reg=issue_reg; tail+1; issue_valid while not ready ignored, no state change.
REQ-022 SHALL drive issue_ready and issue_index combinationally from registered count/tail; no same-cycle bypass of a commit freeing space.
REQ-023 SHALL, on wb_valid with entry[wb_index].busy=1, set done=1 and value=wb_result at the next edge; wb to a non-busy entry ignored.
REQ-024 SHALL retire when entry[head].busy && done (registered): next cycle commit_valid=1, commit_reg/commit_value = entry fields, entry busy=0, head+1; at most one retire per cycle.
REQ-025 SHALL keep commit_valid=0 when not retiring; commit_reg/commit_value hold last value.
REQ-026 SHALL make a writeback to the head entry retire no earlier than the cycle after the write edge (latency wb->commit_valid = 2 edges).
REQ-027 SHALL update count = count + alloc - retire; simultaneous alloc and retire leaves count unchanged.
REQ-028 SHALL drive query outputs combinationally: if wb_valid && wb_index==query_index and entry busy, ready=1, value=wb_result (forward); else ready=busy&&done, value=stored value.
REQ-029 SHALL in-order retire: a done entry behind an undone head waits.

Reset
REQ-030 SHALL on reset clear all busy/done, head=tail=0, count=0, commit_valid=0, commit_reg=0, commit_value=0; reset dominates any same-cycle issue, wb, or retire, including mid-operation.

Structure
REQ-031 SHALL take WORD_SIZE, REG_INDEX, RB_INDEX from the shared parameters include used by the reservation stations; no local redefinition.
REQ-032 SHALL be a single module; entry storage plain register arrays, no sub-module.

Verification
REQ-033 Reset, then issue reg 3, 5 -> issue_index 0 then 1, count=2, commit_valid=0.
REQ-034 wb index 1 = 0x22 before wb index 0 = 0x11 -> commits reg 3/0x11 then reg 5/0x22 on consecutive cycles, in order.
REQ-035 Issue 8 without wb -> count=8, issue_ready=0, 9th issue ignored; then wb index 0 -> retire, issue_ready=1 next cycle, next alloc index 0 (wrap).
REQ-036 wb_valid index 2 = 0xABCD with query_index_j=2 same cycle -> query_ready_j=1, query_value_j=0xABCD combinationally.
REQ-037 Full buffer, head done, issue_valid same cycle as retire -> issue ignored, count 8 -> 7.
REQ-038 Assert reset with 4 entries busy, 2 done -> next cycle count=0, commit_valid=0, issue_index=0, no commits afterwards.
